// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer for the LEGv8 front end.
// Owns the PC, fetches over a req/ack memory port, holds the instruction
// register and steps the control unit through multi-cycle instructions.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | between instructions, waiting for run
//   S_FETCH | imem_req high at pc, waiting for imem_ack
//   S_EXEC  | instr_valid high, one micro-step per cycle, pc follows ps
//   S_HALT  | fault recorded, everything frozen until reset
module instr_fetch_sequencer #(
    parameter int unsigned          ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          MAX_STEPS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [1:0]        cu_state,
    input  logic [1:0]        cu_next_state,
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] k,
    input  logic [ADDR_W-1:0] reg_a,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_link,
    output logic              fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_link;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic [1:0]        r_cu_state;
    logic              r_imem_req;
    logic              r_fault;

    logic [ADDR_W-1:0] w_pc_next;
    logic [31:0]       w_step_ext;
    logic              w_step_fault;
    logic              w_misaligned;

    // Next-PC selection driven by the control word during EXEC.
    always_comb begin
        w_pc_next = r_pc;
        case (ps)
            2'b00:   w_pc_next = r_pc;
            2'b01:   w_pc_next = r_pc + PC_STEP;
            2'b10:   w_pc_next = reg_a;
            default: w_pc_next = r_pc + (k << 2);
        endcase
    end

    assign w_step_ext   = {30'd0, cu_next_state};
    assign w_step_fault = (w_step_ext > MAX_STEPS);
    assign w_misaligned = (w_pc_next[1:0] != 2'b00);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pc_link     <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_cu_state    <= 2'd0;
            r_imem_req    <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc_link     <= r_pc + PC_STEP;
                        r_cu_state    <= 2'd0;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The offending target is still committed to pc on a fault.
                    r_pc <= w_pc_next;
                    if (w_step_fault || w_misaligned) begin
                        r_fault       <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_HALT;
                    end else if (cu_next_state != 2'd0) begin
                        r_cu_state <= cu_next_state;
                    end else begin
                        r_cu_state    <= 2'd0;
                        r_instr_valid <= 1'b0;
                        if (run) begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign cu_state    = r_cu_state;
    assign pc          = r_pc;
    assign pc_link     = r_pc_link;
    assign fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer: a driver plays memory and
// control unit, a reference model predicts fetch addresses and per-step
// execution state, and a monitor checks whatever the DUT presents.
module tb_instr_fetch_sequencer;

    localparam int unsigned ADDR_W = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  cu_state;
    logic [1:0]  cu_next_state = '0;
    logic [1:0]  ps = '0;
    logic [63:0] k = '0;
    logic [63:0] reg_a = '0;
    logic [63:0] pc;
    logic [63:0] pc_link;
    logic        fault;

    instr_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RST_PC),
        .MAX_STEPS (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .cu_state      (cu_state),
        .cu_next_state (cu_next_state),
        .ps            (ps),
        .k             (k),
        .reg_a         (reg_a),
        .pc            (pc),
        .pc_link       (pc_link),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  step;
        logic [63:0] pcv;
        logic [63:0] link;
    } exec_t;

    exec_t       q_exec[$];
    logic [63:0] q_fetch[$];

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] m_pc;
    logic [1:0]  p_ps[4];
    logic [63:0] p_k[4];
    logic [63:0] p_rega[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got event expected none (or timeout)", name);
    endtask

    // Architectural PC rule, written from the instruction-set view.
    function automatic logic [63:0] model_pc(input logic [63:0] cur, input logic [1:0] sel,
                                             input logic [63:0] off, input logic [63:0] tgt);
        case (sel)
            2'd0:    return cur;
            2'd1:    return cur + 64'd4;
            2'd2:    return tgt;
            default: return cur + off * 64'd4;
        endcase
    endfunction

    // Monitor: checks fetch addresses on accepted requests and each executing step.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_req && imem_ack) begin
                if (q_fetch.size() == 0) fail_now("fetch_unexpected");
                else chk("fetch_addr", imem_addr, q_fetch.pop_front());
            end
            if (instr_valid) begin
                if (q_exec.size() == 0) fail_now("exec_unexpected");
                else begin
                    exec_t e;
                    e = q_exec.pop_front();
                    chk("exec_instr", {32'd0, instr}, {32'd0, e.word});
                    chk("exec_state", {62'd0, cu_state}, {62'd0, e.step});
                    chk("exec_pc", pc, e.pcv);
                    chk("exec_link", pc_link, e.link);
                end
            end
        end
    end

    // One instruction: wait for request, ack after wait_n cycles, then drive nsteps micro-steps.
    task automatic do_instr(input logic [31:0] word, input int wait_n, input int nsteps,
                            input logic last_run);
        int guard;
        logic [63:0] link;
        q_fetch.push_back(m_pc);
        run = 1'b1;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!imem_req) begin
            fail_now("fetch_timeout");
            void'(q_fetch.pop_back());
            return;
        end
        for (int w = 0; w < wait_n; w++) begin
            chk("req_hold", {63'd0, imem_req}, 64'd1);
            chk("addr_hold", imem_addr, m_pc);
            chk("instr_hold_valid", {63'd0, instr_valid}, 64'd0);
            @(posedge clock); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        link = m_pc + 64'd4;
        q_exec.push_back('{word, 2'd0, m_pc, link});
        @(posedge clock); #1;
        for (int s = 0; s < nsteps; s++) begin
            ps            = p_ps[s];
            k             = p_k[s];
            reg_a         = p_rega[s];
            cu_next_state = (s == nsteps - 1) ? 2'd0 : 2'(s + 1);
            run           = (s == nsteps - 1) ? last_run : 1'($urandom_range(1));
            imem_ack      = 1'($urandom_range(1));
            imem_rdata    = $urandom;
            m_pc = model_pc(m_pc, p_ps[s], p_k[s], p_rega[s]);
            if (s != nsteps - 1) q_exec.push_back('{word, 2'(s + 1), m_pc, link});
            @(posedge clock); #1;
        end
        imem_ack      = 1'b0;
        cu_next_state = 2'd0;
        ps            = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        logic lr;
        #23;
        chk("rst_pc", pc, RST_PC);
        chk("rst_link", pc_link, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_state", {62'd0, cu_state}, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_pc = RST_PC;

        // ADDI at reset PC
        p_ps[0] = 2'd1; p_k[0] = '0; p_rega[0] = '0;
        do_instr(32'h91000420, 1, 1, 1'b1);
        // BR to 0x200
        p_ps[0] = 2'd2; p_rega[0] = 64'h200;
        do_instr(32'hD61F0000, 0, 1, 1'b1);
        // B -4 words from 0x200
        p_ps[0] = 2'd3; p_k[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        do_instr(32'h17FFFFFC, 0, 1, 1'b1);
        // BR to 0x300
        p_ps[0] = 2'd2; p_rega[0] = 64'h300;
        do_instr(32'hD61F0020, 0, 1, 1'b1);
        // BL two-step
        p_ps[0] = 2'd3; p_k[0] = 64'h10;
        p_ps[1] = 2'd0; p_k[1] = '0; p_rega[1] = '0;
        do_instr(32'h94000010, 0, 2, 1'b1);
        chk("bl_pc", pc, 64'h340);
        // Memory wait of 5 cycles
        p_ps[0] = 2'd1;
        do_instr(32'h8B020020, 5, 1, 1'b1);
        // run dropped on last step
        do_instr(32'h8B030040, 0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("idle_req", {63'd0, imem_req}, 64'd0);
            @(posedge clock); #1;
        end

        // Randomised instructions
        for (int n = 0; n < 40; n++) begin
            int ns;
            ns = int'($urandom_range(3, 1));
            for (int s = 0; s < ns; s++) begin
                longint kk;
                kk = longint'($urandom_range(64)) - 64'sd32;
                p_ps[s]   = 2'($urandom_range(3));
                p_k[s]    = 64'(kk);
                p_rega[s] = {$urandom, $urandom} & ~64'h3;
            end
            lr = ($urandom_range(3) != 0);
            do_instr($urandom, int'($urandom_range(4)), ns, lr);
            if (!lr) begin
                for (int i = 0; i < 2; i++) begin
                    chk("rand_idle_req", {63'd0, imem_req}, 64'd0);
                    @(posedge clock); #1;
                end
            end
        end

        // Reset in the middle of a memory wait
        run = 1'b1;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("midrst_req", {63'd0, imem_req}, 64'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(posedge clock); #1;
        run = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        imem_ack = 1'b0;
        chk("late_ack_instr", {32'd0, instr}, 64'd0);
        chk("late_ack_valid", {63'd0, instr_valid}, 64'd0);
        chk("late_ack_req", {63'd0, imem_req}, 64'd0);
        m_pc = RST_PC;

        // Misaligned BR target faults and halts
        p_ps[0] = 2'd2; p_rega[0] = 64'h402;
        do_instr(32'hD61F0060, 0, 1, 1'b1);
        chk("fault_flag", {63'd0, fault}, 64'd1);
        chk("fault_pc", pc, 64'h402);
        chk("fault_valid", {63'd0, instr_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'($urandom_range(1));
            @(posedge clock); #1;
            chk("halt_req", {63'd0, imem_req}, 64'd0);
            chk("halt_fault", {63'd0, fault}, 64'd1);
        end
        imem_ack = 1'b0;

        chk("exec_queue_empty", 64'(q_exec.size()), 64'd0);
        chk("fetch_queue_empty", 64'(q_fetch.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
